// File: rtl/ao_dot_acc.sv
// Streaming signed dot-product accumulator with sticky overflow.
// Beats in over valid/ready, one result out per dot product.
module ao_dot_acc #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_valid,
    input  logic [31:0]      p_data,
    input  logic             p_last,
    output logic             p_ready,
    output logic             res_valid,
    output logic [ACC_W-1:0] res_data,
    output logic [CNT_W-1:0] res_cnt,
    output logic             res_ovf,
    input  logic             res_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             add_ovf;
    logic             take;

    assign p_ext   = {{(ACC_W-32){p_data[31]}}, p_data};
    assign sum     = acc + p_ext;
    assign add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc[ACC_W-1]);
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign take    = p_valid && p_ready;

    // FSM with registered handshake outputs; p_ready stays low through reset
    // and rises on the first edge after release because IDLE re-arms it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            res_data  <= '0;
            res_cnt   <= '0;
            res_ovf   <= 1'b0;
            res_valid <= 1'b0;
            p_ready   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    p_ready <= 1'b1;
                    if (take) begin
                        if (p_last) begin
                            res_data  <= p_ext;
                            res_cnt   <= CNT_ONE;
                            res_ovf   <= 1'b0;
                            res_valid <= 1'b1;
                            p_ready   <= 1'b0;
                            state     <= OUT;
                        end else begin
                            acc   <= p_ext;
                            cnt   <= CNT_ONE;
                            ovf   <= 1'b0;
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (take) begin
                        if (p_last) begin
                            res_data  <= sum;
                            res_cnt   <= cnt_inc;
                            res_ovf   <= ovf | add_ovf;
                            res_valid <= 1'b1;
                            p_ready   <= 1'b0;
                            state     <= OUT;
                        end else begin
                            acc <= sum;
                            cnt <= cnt_inc;
                            ovf <= ovf | add_ovf;
                        end
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        res_valid <= 1'b0;
                        p_ready   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    p_ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ao_dot_acc.sv
// Randomized bench for ao_dot_acc: two instances (40/8 and 33/3) share
// stimulus and are checked against an arithmetic reference model.
module tb_ao_dot_acc;

    localparam int W0 = 40;
    localparam int C0 = 8;
    localparam int W1 = 33;
    localparam int C1 = 3;

    typedef struct {
        longint data;
        longint cnt;
        logic   ovf;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p_valid = 1'b0;
    logic [31:0]   p_data = '0;
    logic          p_last = 1'b0;
    logic          res_ready = 1'b0;

    logic          p_ready0, res_valid0, res_ovf0;
    logic [W0-1:0] res_data0;
    logic [C0-1:0] res_cnt0;
    logic          p_ready1, res_valid1, res_ovf1;
    logic [W1-1:0] res_data1;
    logic [C1-1:0] res_cnt1;

    ao_dot_acc #(.ACC_W(W0), .CNT_W(C0)) dut0 (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_data(p_data), .p_last(p_last),
        .p_ready(p_ready0),
        .res_valid(res_valid0), .res_data(res_data0),
        .res_cnt(res_cnt0), .res_ovf(res_ovf0),
        .res_ready(res_ready)
    );

    ao_dot_acc #(.ACC_W(W1), .CNT_W(C1)) dut1 (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_data(p_data), .p_last(p_last),
        .p_ready(p_ready1),
        .res_valid(res_valid1), .res_data(res_data1),
        .res_cnt(res_cnt1), .res_ovf(res_ovf1),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   rst_age = 0;
    int   rr_pct = 100;
    logic took = 1'b0;
    int   cur[$];
    res_t exp0[$];
    res_t exp1[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic longint wrap(input longint s, input int w);
        longint m, hi, r;
        m  = 64'sd1 <<< w;
        hi = (64'sd1 <<< (w - 1)) - 1;
        r  = s % m;
        if (r < 0) r += m;
        if (r > hi) r -= m;
        return r;
    endfunction

    // Exact signed sums; an addition overflows when its true value leaves
    // the w-bit signed range, and the running value then wraps.
    function automatic res_t model(input int q[$], input int w, input int cw);
        res_t   r;
        longint a, s, p, lo, hi, cmax;
        lo   = -(64'sd1 <<< (w - 1));
        hi   = (64'sd1 <<< (w - 1)) - 1;
        cmax = (64'sd1 <<< cw) - 1;
        a    = 0;
        r.cnt = 0;
        r.ovf = 1'b0;
        foreach (q[i]) begin
            p = longint'(q[i]);
            if (i == 0) begin
                a = p;
            end else begin
                s = a + p;
                if (s > hi || s < lo) r.ovf = 1'b1;
                a = wrap(s, w);
            end
            if (r.cnt < cmax) r.cnt++;
        end
        r.data = a;
        return r;
    endfunction

    function automatic logic rr();
        return $urandom_range(0, 99) < rr_pct;
    endfunction

    task automatic observe();
        logic exp_rv, exp_pr;
        took = 1'b0;
        if (rst) begin
            rst_age = 0;
            cur.delete();
            exp0.delete();
            exp1.delete();
            check("rst_pready0", p_ready0, 0);
            check("rst_pready1", p_ready1, 0);
            check("rst_rvalid0", res_valid0, 0);
            check("rst_rvalid1", res_valid1, 0);
            return;
        end
        if (rst_age < 10) rst_age++;
        exp_rv = exp0.size() > 0;
        exp_pr = (rst_age >= 2) && !exp_rv;
        check("rvalid0", res_valid0, exp_rv);
        check("rvalid1", res_valid1, exp_rv);
        check("pready0", p_ready0, exp_pr);
        check("pready1", p_ready1, exp_pr);
        if (exp_rv) begin
            check("data0", longint'($signed(res_data0)), exp0[0].data);
            check("cnt0", 64'(res_cnt0), exp0[0].cnt);
            check("ovf0", res_ovf0, exp0[0].ovf);
            check("data1", longint'($signed(res_data1)), exp1[0].data);
            check("cnt1", 64'(res_cnt1), exp1[0].cnt);
            check("ovf1", res_ovf1, exp1[0].ovf);
            if (res_ready) begin
                void'(exp0.pop_front());
                void'(exp1.pop_front());
            end
        end
        if (p_valid && exp_pr) begin
            took = 1'b1;
            cur.push_back(int'(p_data));
            if (p_last) begin
                exp0.push_back(model(cur, W0, C0));
                exp1.push_back(model(cur, W1, C1));
                cur.delete();
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input int nbub);
        for (int i = 0; i < nbub; i++) begin
            p_valid   = 1'b0;
            p_data    = $urandom;
            p_last    = 1'($urandom);
            res_ready = rr();
            step();
        end
        p_valid = 1'b1;
        p_data  = d;
        p_last  = l;
        took    = 1'b0;
        for (int i = 0; i < 200 && !took; i++) begin
            res_ready = rr();
            step();
        end
        check("send_accept", took, 1);
        p_valid = 1'b0;
    endtask

    task automatic drain();
        p_valid   = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step();
        check("rst_data", 64'(res_data0), 0);
        check("rst_cnt", 64'(res_cnt0), 0);
        check("rst_ovf", res_ovf0, 0);
        rst = 1'b0;
        step();
        step();

        rr_pct = 100;
        send(32'd100, 1'b0, 0);
        send(-32'sd30, 1'b0, 0);
        send(32'd7, 1'b1, 0);
        check("d3_valid", res_valid0, 1);
        check("d3_data", longint'($signed(res_data0)), 77);
        check("d3_cnt", 64'(res_cnt0), 3);
        check("d3_ovf", res_ovf0, 0);
        drain();

        send(32'h8000_0000, 1'b1, 0);
        check("min_data", longint'($signed(res_data0)), -64'sd2147483648);
        check("min_cnt", 64'(res_cnt0), 1);
        drain();

        send(32'h7FFF_FFFF, 1'b0, 0);
        send(32'h7FFF_FFFF, 1'b0, 0);
        send(32'h0000_0002, 1'b1, 0);
        // 2^32 does not fit a 33-bit signed value: pattern 1_0000_0000
        check("w33_ovf", res_ovf1, 1);
        check("w33_data", 64'(res_data1), 64'h1_0000_0000);
        check("w33_cnt", 64'(res_cnt1), 3);
        check("w40_ovf", res_ovf0, 0);
        drain();

        rr_pct = 0;
        send(32'd5, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            p_valid   = 1'b1;
            p_data    = $urandom;
            p_last    = 1'($urandom);
            res_ready = 1'b0;
            step();
        end
        p_data    = 32'd3;
        p_last    = 1'b1;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        step();
        check("bp_accept", took, 1);
        p_valid = 1'b0;
        drain();

        rr_pct = 100;
        for (int i = 0; i < 4; i++)
            send(32'd1, i == 3, $urandom_range(0, 3));
        check("bub_data", longint'($signed(res_data0)), 4);
        check("bub_cnt", 64'(res_cnt0), 4);
        drain();

        send(32'd50, 1'b0, 0);
        send(32'd50, 1'b0, 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        check("rst_novalid", res_valid0, 0);
        send(32'd9, 1'b1, 0);
        check("post_rst_data", longint'($signed(res_data0)), 9);
        check("post_rst_cnt", 64'(res_cnt0), 1);
        drain();

        rr_pct = 0;
        send(32'd4, 1'b1, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        check("out_rst_novalid", res_valid0, 0);

        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(1, 12);
            rr_pct = $urandom_range(30, 100);
            for (int b = 0; b < n; b++) begin
                logic [31:0] d;
                d = (t % 3 == 0) ? ($urandom_range(0, 1) ? 32'h7FFF_FFF0
                                                         : 32'h8000_0010)
                                 : $urandom;
                send(d, b == n - 1, $urandom_range(0, 2));
            end
        end
        drain();

        rr_pct = 100;
        for (int b = 0; b < 300; b++)
            send($urandom, b == 299, 0);
        check("sat_cnt0", 64'(res_cnt0), 255);
        check("sat_cnt1", 64'(res_cnt1), 7);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
